axi_burst_master: RTL

//  AXI4 initiator that turns simple command/stream requests into single INCR bursts on an AXI4 master port.

---
 rtl/axi_master_pkg.sv | 35 +++
 rtl/axi_burst_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_pkg.sv
// Package for the AXI4 burst master.
// Contents:
//   state_t         FSM states.
//   OKAY..DECERR    AXI response codes.
//   AXI_BURST_INCR  AxBURST encoding for INCR bursts.
//   crosses_4k()    Tests whether a burst runs past a 4 KiB boundary.
package axi_master_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      AW   = 3'd1,
      W    = 3'd2,
      B    = 3'd3,
      AR   = 3'd4,
      R    = 3'd5
   } state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // A burst crosses the boundary when it ends beyond byte 4096 of its page.
   // The sum is done in 32 bits, so it cannot overflow for any 8-bit length.
   function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                       input logic [7:0]  len,
                                       input int unsigned strb_width);
      int unsigned end_byte;
      end_byte = {20'd0, addr_lo} + ({24'd0, len} + 32'd1) * strb_width;
      return end_byte > 32'd4096;
   endfunction

endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one command, plus its write or read stream, into a
// single AXI4 INCR burst. Only one transaction is in flight at a time.
//
// Optional feature: with AXI_MASTER_4K_CHECK_EN defined, a command whose burst
// would cross a 4 KiB boundary is accepted but not issued. done_valid then
// pulses with SLVERR.
//
// Ports:
//   clk, rst           Clock and synchronous active-high reset.
//   cmd_*              Command request. Accepted only in IDLE.
//   wr_data/valid/ready   Write payload stream. It maps onto the W channel.
//   rd_data/valid/ready/last  Read payload stream. It maps from the R channel.
//   done_valid/resp    One-cycle completion pulse and its response.
//   m_axi_aw/w/b/ar/r  AXI4 master port.
//   dbg_state          Current FSM state, for observation.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid, once raised, keeps its payload stable until that
// transfer.
module axi_burst_master
   import axi_master_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  rd_last,
   output logic                  done_valid,
   output logic [1:0]            done_resp,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output state_t                dbg_state
);

   localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            cnt_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [1:0]            rresp_max_q, rresp_max_n;
   logic                  rerr_q;
   logic                  done_valid_q;
   logic [1:0]            done_resp_q;
   logic [ADDR_WIDTH-1:0] cmd_addr_aligned;

   logic cmd_fire, cmd_reject, w_beat, b_fire, r_beat, r_final, r_err_beat;

   // BID and RID are not checked.
   logic unused_ids;
   assign unused_ids = ^{m_axi_bid, m_axi_rid};

   assign cmd_addr_aligned = cmd_addr & ALIGN_MASK;

   // Commands are held off during the done pulse. This puts the earliest next
   // accept one cycle after done_valid.
   assign cmd_ready = (state == IDLE) && !done_valid_q;

   always_comb begin
      state_n     = state;
      cmd_fire    = cmd_valid && cmd_ready;
      cmd_reject  = 1'b0;
      w_beat      = 1'b0;
      b_fire      = 1'b0;
      r_beat      = 1'b0;
      r_final     = 1'b0;
      r_err_beat  = 1'b0;
      rresp_max_n = rresp_max_q;
      case (state)
         IDLE: begin
            if (cmd_fire) begin
`ifdef AXI_MASTER_4K_CHECK_EN
               cmd_reject = crosses_4k(cmd_addr_aligned[11:0], cmd_len, STRB_WIDTH);
`else
               cmd_reject = 1'b0;
`endif
               if (!cmd_reject) state_n = cmd_write ? AW : AR;
            end
         end
         AW: if (m_axi_awready) state_n = W;
         W: begin
            w_beat = wr_valid && m_axi_wready;
            if (w_beat && (cnt_q == 8'd0)) state_n = B;
         end
         B: begin
            b_fire = m_axi_bvalid;
            if (b_fire) state_n = IDLE;
         end
         AR: if (m_axi_arready) state_n = R;
         R: begin
            r_beat = m_axi_rvalid && rd_ready;
            if (r_beat) begin
               // Either the slave's rlast or our own count ends the burst.
               // Any disagreement between the two is a beat-count error.
               r_final     = m_axi_rlast || (cnt_q == 8'd0);
               r_err_beat  = m_axi_rlast != (cnt_q == 8'd0);
               rresp_max_n = (m_axi_rresp > rresp_max_q) ? m_axi_rresp : rresp_max_q;
               if (r_final) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         id_q         <= '0;
         rresp_max_q  <= OKAY;
         rerr_q       <= 1'b0;
         done_valid_q <= 1'b0;
         done_resp_q  <= OKAY;
      end else begin
         state        <= state_n;
         done_valid_q <= 1'b0;
         if (cmd_fire) begin
            addr_q      <= cmd_addr_aligned;
            len_q       <= cmd_len;
            cnt_q       <= cmd_len;
            id_q        <= cmd_id;
            rresp_max_q <= OKAY;
            rerr_q      <= 1'b0;
         end
         if (cmd_reject) begin
            done_valid_q <= 1'b1;
            done_resp_q  <= SLVERR;
         end
         if (w_beat) cnt_q <= cnt_q - 8'd1;
         if (b_fire) begin
            done_valid_q <= 1'b1;
            done_resp_q  <= m_axi_bresp;
         end
         if (r_beat) begin
            cnt_q       <= cnt_q - 8'd1;
            rresp_max_q <= rresp_max_n;
            rerr_q      <= rerr_q | r_err_beat;
            if (r_final) begin
               done_valid_q <= 1'b1;
               done_resp_q  <= (rerr_q || r_err_beat) ? SLVERR : rresp_max_n;
            end
         end
      end
   end

   assign dbg_state  = state;
   assign done_valid = done_valid_q;
   assign done_resp  = done_resp_q;

   assign m_axi_awid    = id_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = len_q;
   assign m_axi_awsize  = AXSIZE;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = (state == AW);

   assign m_axi_wdata  = wr_data;
   assign m_axi_wstrb  = '1;
   assign m_axi_wlast  = (state == W) && (cnt_q == 8'd0);
   assign m_axi_wvalid = (state == W) && wr_valid;
   assign wr_ready     = (state == W) && m_axi_wready;

   assign m_axi_bready = (state == B);

   assign m_axi_arid    = id_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = len_q;
   assign m_axi_arsize  = AXSIZE;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = (state == AR);

   assign rd_data      = m_axi_rdata;
   assign rd_valid     = (state == R) && m_axi_rvalid;
   assign rd_last      = (state == R) && m_axi_rlast;
   assign m_axi_rready = (state == R) && rd_ready;

endmodule
